mult_control: RTL and testbench
===============================

# mult_control

Sequencing controller for the shift-add multiplier datapath. It owns the iteration counter and drives the operand-load, accumulate and shift strobes for each multiplier bit. It pulses `Done` after exactly `N` shift iterations. It sits between the core's multiply request and the multiplier's accumulator and shift registers.

## Interface
- `N`, default 32: operand width, which is also the number of shift iterations. Minimum 2.
- `CW`, default `$clog2(N)`: iteration counter width.

Ports:
- `Clk` in 1: clock; all state updates on the rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `Start` in 1: request, level-sensitive, sampled only in IDLE.
- `Lsb` in 1: bit 0 of the datapath multiplier/product-low register, sampled only in TEST.
- `Load` out 1: load operands into the datapath and clear the accumulator.
- `Add` out 1: accumulator ← accumulator + multiplicand.
- `Shift` out 1: shift the product/multiplier pair right by one.
- `Done` out 1: one-cycle completion pulse.
- `Busy` out 1: high in every state except IDLE.
- `Iter` out CW: current iteration index, 0..N-1.

## Operation
- FSM states: IDLE, LOAD, TEST, ADD, SHIFT, DONE.
- All outputs are Moore outputs decoded from the registered state. At most one of `Load`/`Add`/`Shift`/`Done` is high in any cycle.
- IDLE:
  - `Start`=1 → LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - `Load`=1; the counter clears to 0.
  - → TEST.
- TEST:
  - No strobe.
  - `Lsb`=1 → ADD.
  - `Lsb`=0 → SHIFT.
- ADD:
  - `Add`=1.
  - → SHIFT.
- SHIFT:
  - `Shift`=1.
  - If `K` (`Iter`==N-1) → DONE, and `Iter` holds.
  - Otherwise `Iter`++ and → TEST.
- DONE:
  - `Done`=1.
  - → IDLE unconditionally.
- Counter rules:
  - Clears only in LOAD and increments only in SHIFT with `K`=0, so it never wraps.
  - `K` is combinational from `Iter`.
- `Start` handling:
  - `Start` in any state other than IDLE is ignored; there is no queuing.
  - If `Start` is still high when IDLE is re-entered, a new operation begins the next cycle. This is back-to-back operation: one IDLE cycle between `Done` and the next `Load`.
- Reset:
  - `Reset` asserted at any time, including mid-operation, forces IDLE immediately.
  - All outputs go to 0 and `Iter` to 0. The datapath result is discarded and `Done` is not pulsed.
  - First `Start` sampling occurs at the first rising edge after `Reset` deasserts.

## Timing
- Reset values: `Load`=`Add`=`Shift`=`Done`=`Busy`=0, `Iter`=0, state IDLE.
- Request timing: `Start` sampled high at edge t gives `Load` and `Busy` high during cycle t+1.
- Per bit: 2 cycles (TEST, SHIFT) if `Lsb`=0; 3 cycles (TEST, ADD, SHIFT) if `Lsb`=1.
- Total latency from first `Load` cycle to `Done` cycle inclusive: 2N + P + 2 cycles, where P is the number of 1 bits in the multiplier.
- `Busy` falls in the cycle after DONE.
- `Lsb` must be valid by the TEST cycle. The datapath updates `Lsb` on the `Shift` edge, which always precedes the next TEST.

## Structure
- Shared package `mult_pkg` holds:
  - the state encoding constants (IDLE..DONE, 3-bit binary);
  - default `N`=32;
  - `CW` derivation.
  These are reused by the datapath and bench.
- Sub-module `iter_counter` has ports `Clk`, `Reset`, `Clear`, `Inc`, `Iter`[CW], `K`:
  - synchronous clear;
  - increment;
  - terminal flag `K` = (`Iter`==N-1).
- The FSM lives in `mult_control`.

## Test plan
- **Reset:** hold `Reset`=1 with `Start`=1 → all outputs 0 and `Iter`=0. Deassert → `Load`=1 one cycle later.
- **Mixed bits:** N=4, multiplier 4'b1011 (`Lsb` sequence 1,1,0,1) → strobe order Load, -, Add, Shift, -, Add, Shift, -, Shift, -, Add, Shift, Done. That is 13 cycles, `Iter` ending at 3, `Done` high exactly 1 cycle.
- **All zeros / all ones:** N=4, multiplier 0 → 10 cycles, `Add` never asserted. Multiplier 4'b1111 → 14 cycles, 4 `Add` pulses.
- **Busy Start / back-to-back:** pulse `Start` during ADD → ignored, single `Done`. Hold `Start` high continuously → second `Load` occurs exactly 2 cycles after the first `Done`.
- **Mid-operation reset:** assert `Reset` asynchronously during the second SHIFT → outputs 0 before the next edge, no `Done`. A fresh `Start` then completes normally with `Iter` restarting from 0.
- **Width check:** N=32, random multiplier → cycle count 66 + popcount, with exactly 32 `Shift` pulses.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: state encoding, default
// operand width and iteration-counter width derivation.
package mult_pkg;

    localparam int unsigned MULT_N_DEFAULT = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_TEST  = 3'd2,
        ST_ADD   = 3'd3,
        ST_SHIFT = 3'd4,
        ST_DONE  = 3'd5
    } mult_state_e;

    function automatic int unsigned iter_width(input int unsigned n);
        return (n < 32'd2) ? 32'd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mult_control_iter_counter.sv
// Iteration counter for the multiplier: synchronous clear, increment that
// saturates at N-1, and terminal flag K raised on the last iteration.
module iter_counter
    import mult_pkg::*;
#(
    parameter int unsigned N  = MULT_N_DEFAULT,
    parameter int unsigned CW = iter_width(N)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Clear,
    input  logic          Inc,
    output logic [CW-1:0] Iter,
    output logic          K
);

    logic [CW-1:0] iter_q;
    logic [CW-1:0] iter_d;

    assign K    = (iter_q == CW'(N - 32'd1));
    assign Iter = iter_q;

    // Next count: clear wins, increment never passes the terminal value.
    always_comb begin
        iter_d = iter_q;
        if (Clear) begin
            iter_d = '0;
        end else if (Inc && !K) begin
            iter_d = iter_q + CW'(1);
        end else begin
            iter_d = iter_q;
        end
    end

    // Counter register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            iter_q <= '0;
        end else begin
            iter_q <= iter_d;
        end
    end

endmodule

// File: rtl/mult_control.sv
// Sequencing FSM for the shift-add multiplier: issues Load, then Add/Shift
// per multiplier bit, and pulses Done after N shift iterations.
module mult_control
    import mult_pkg::*;
#(
    parameter int unsigned N  = MULT_N_DEFAULT,
    parameter int unsigned CW = iter_width(N)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Lsb,
    output logic          Load,
    output logic          Add,
    output logic          Shift,
    output logic          Done,
    output logic          Busy,
    output logic [CW-1:0] Iter
);

    mult_state_e state_q, state_d;
    logic load_q, add_q, shift_q, done_q, busy_q;
    logic load_d, add_d, shift_d, done_d, busy_d;
    logic k_s;

    iter_counter #(.N(N), .CW(CW)) u_iter (
        .Clk   (Clk),
        .Reset (Reset),
        .Clear (state_q == ST_LOAD),
        .Inc   (state_q == ST_SHIFT),
        .Iter  (Iter),
        .K     (k_s)
    );

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = Start ? ST_LOAD : ST_IDLE;
            ST_LOAD:  state_d = ST_TEST;
            ST_TEST:  state_d = Lsb ? ST_ADD : ST_SHIFT;
            ST_ADD:   state_d = ST_SHIFT;
            ST_SHIFT: state_d = k_s ? ST_DONE : ST_TEST;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so the registered copies
    // line up with the state register cycle for cycle.
    always_comb begin
        load_d  = 1'b0;
        add_d   = 1'b0;
        shift_d = 1'b0;
        done_d  = 1'b0;
        busy_d  = (state_d != ST_IDLE);
        case (state_d)
            ST_LOAD:  load_d  = 1'b1;
            ST_ADD:   add_d   = 1'b1;
            ST_SHIFT: shift_d = 1'b1;
            ST_DONE:  done_d  = 1'b1;
            default:  load_d  = 1'b0;
        endcase
    end

    // State and output registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            load_q  <= 1'b0;
            add_q   <= 1'b0;
            shift_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            add_q   <= add_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign Load  = load_q;
    assign Add   = add_q;
    assign Shift = shift_q;
    assign Done  = done_q;
    assign Busy  = busy_q;

endmodule

// File: tb/tb_mult_control.sv
// Randomized self-checking bench for mult_control at N=4 and N=32, compared
// against a per-bit schedule model built from the multiplier value.
module tb_mult_control;
    import mult_pkg::*;

    localparam int unsigned NS = 4;
    localparam int unsigned NL = 32;
    localparam int unsigned CS = iter_width(NS);
    localparam int unsigned CL = iter_width(NL);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] start;
    logic [1:0] lsb;
    logic load_s, add_s, shift_s, done_s, busy_s;
    logic load_l, add_l, shift_l, done_l, busy_l;
    logic [CS-1:0] iter_s;
    logic [CL-1:0] iter_l;

    int n_vec = 0;
    int n_miscmp = 0;
    int prev_iter [2] = '{0, 0};

    mult_control #(.N(NS)) u_small (
        .Clk(clk), .Reset(rst), .Start(start[0]), .Lsb(lsb[0]),
        .Load(load_s), .Add(add_s), .Shift(shift_s), .Done(done_s),
        .Busy(busy_s), .Iter(iter_s)
    );

    mult_control #(.N(NL)) u_large (
        .Clk(clk), .Reset(rst), .Start(start[1]), .Lsb(lsb[1]),
        .Load(load_l), .Add(add_l), .Shift(shift_l), .Done(done_l),
        .Busy(busy_l), .Iter(iter_l)
    );

    // Layout: [9]=Load [8]=Add [7]=Shift [6]=Done [5]=Busy [4:0]=Iter
    function automatic logic [31:0] obs_vec(input int sel);
        if (sel == 0)
            return {22'd0, load_s, add_s, shift_s, done_s, busy_s, 3'd0, iter_s};
        else
            return {22'd0, load_l, add_l, shift_l, done_l, busy_l, iter_l};
    endfunction

    // kind: 0 idle, 1 load, 2 test, 3 add, 4 shift, 5 done
    function automatic logic [31:0] exp_vec(input int kind, input int it);
        return {22'd0, kind == 1, kind == 3, kind == 4, kind == 5, kind != 0, 5'(it)};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input int sel, input int n, input logic [31:0] m,
                          input bit hold, input bit pulse_add, input int abort_shift);
        int  kinds[$];
        int  its[$];
        bit  bits[$];
        int  adds = 0, shifts = 0, dones = 0, span = 0, shift_seen = 0;
        bit  in_span = 1'b0;
        logic [31:0] o, mask;
        string tag;

        kinds.push_back(1); its.push_back(prev_iter[sel]); bits.push_back(m[0]);
        for (int i = 0; i < n; i++) begin
            kinds.push_back(2); its.push_back(i); bits.push_back(m[i]);
            if (m[i]) begin
                kinds.push_back(3); its.push_back(i); bits.push_back(m[i]);
            end
            kinds.push_back(4); its.push_back(i); bits.push_back(m[i]);
        end
        kinds.push_back(5); its.push_back(n - 1); bits.push_back(1'b0);
        kinds.push_back(0); its.push_back(n - 1); bits.push_back(1'b0);
        if (!hold) begin
            kinds.push_back(0); its.push_back(n - 1); bits.push_back(1'b0);
        end

        start[sel] = 1'b1;
        lsb[sel]   = m[0];
        for (int k = 0; k < kinds.size(); k++) begin
            @(posedge clk);
            #1;
            o = obs_vec(sel);
            tag = $sformatf("n%0d m%h c%0d", n, m, k);
            check_eq(tag, o, exp_vec(kinds[k], its[k]));
            adds   += int'(o[8]);
            shifts += int'(o[7]);
            dones  += int'(o[6]);
            if (o[9]) in_span = 1'b1;
            if (in_span) span++;
            if (o[6]) in_span = 1'b0;
            if (kinds[k] == 4) shift_seen++;
            if (abort_shift != 0 && shift_seen == abort_shift) begin
                start[sel] = 1'b0;
                #1 rst = 1'b1;
                #1 check_eq("abort_async", obs_vec(sel), exp_vec(0, 0));
                @(posedge clk);
                #1 check_eq("abort_held", obs_vec(sel), exp_vec(0, 0));
                rst = 1'b0;
                check_eq("abort_no_done", 32'(dones), 32'd0);
                prev_iter[sel] = 0;
                return;
            end
            start[sel] = hold || (pulse_add && kinds[k] == 3);
            lsb[sel]   = bits[k];
        end

        mask = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        check_eq($sformatf("adds m%h", m), 32'(adds), 32'($countones(m & mask)));
        check_eq($sformatf("shifts m%h", m), 32'(shifts), 32'(n));
        check_eq($sformatf("dones m%h", m), 32'(dones), 32'd1);
        check_eq($sformatf("latency m%h", m), 32'(span), 32'(2 * n + $countones(m & mask) + 2));
        prev_iter[sel] = n - 1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        start = 2'b01;
        lsb   = 2'b00;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_eq("rst_small", obs_vec(0), exp_vec(0, 0));
            check_eq("rst_large", obs_vec(1), exp_vec(0, 0));
        end
        rst = 1'b0;

        run_op(0, NS, 32'hB, 1'b0, 1'b0, 0);
        run_op(0, NS, 32'h0, 1'b0, 1'b0, 0);
        run_op(0, NS, 32'hF, 1'b0, 1'b0, 0);
        run_op(0, NS, 32'hB, 1'b0, 1'b1, 0);
        run_op(0, NS, 32'h5, 1'b1, 1'b0, 0);
        run_op(0, NS, 32'h6, 1'b0, 1'b0, 0);
        run_op(0, NS, 32'hD, 1'b0, 1'b0, 2);
        run_op(0, NS, 32'h9, 1'b0, 1'b0, 0);

        for (int r = 0; r < 8; r++) begin
            run_op(0, NS, 32'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 0);
        end
        run_op(0, NS, 32'($urandom_range(0, 15)), 1'b0, 1'b0, 0);

        run_op(1, NL, 32'h0, 1'b0, 1'b0, 0);
        run_op(1, NL, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        for (int r = 0; r < 4; r++) begin
            run_op(1, NL, $urandom(), 1'b0, 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
